// File: rtl/sample_fetch_arbiter_if.sv
// Voice-side request/ack bus and memory-side read handshake of the sample fetch arbiter.
// The arbiter uses the master modport; voices and the memory port use the slave modport.
interface sample_fetch_arbiter_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 24
);
    logic                         s_enable;
    logic [NUM_VOICES-1:0]        voice_req;
    logic [NUM_VOICES*ADDR_W-1:0] voice_addr;
    logic [NUM_VOICES-1:0]        voice_ack;
    logic [15:0]                  voice_data;
    logic [ADDR_W-1:0]            s_addr;
    logic                         s_read;
    logic                         s_ready;
    logic [15:0]                  s_data;
    logic                         timeout_err;
    logic                         busy;

    modport master (
        input  s_enable, voice_req, voice_addr, s_ready, s_data,
        output voice_ack, voice_data, s_addr, s_read, timeout_err, busy
    );

    modport slave (
        output s_enable, voice_req, voice_addr, s_ready, s_data,
        input  voice_ack, voice_data, s_addr, s_read, timeout_err, busy
    );
endinterface

// File: rtl/sample_fetch_arbiter.sv
// Round-robin arbiter sharing one sample-memory read port among playback voices.
// Each fetch runs IDLE -> WAIT -> DONE; a fetch without s_ready is abandoned after TIMEOUT cycles.
module sample_fetch_arbiter #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          CLK,
    input  logic                          RESET,
    sample_fetch_arbiter_if.master        bus
);
    localparam int unsigned IDX_W        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned CAND_W       = IDX_W + 1;
    localparam logic [9:0]  TIMEOUT_LAST = 10'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]  ack_q, ack_d;
    logic [15:0]            data_q, data_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   read_q, read_d;
    logic                   err_q, err_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [CAND_W-1:0]      cand;
    logic                   start_fetch;
    logic                   timed_out;

    // First requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            cand = {1'b0, rr_ptr_q} + CAND_W'(i);
            if (cand >= CAND_W'(NUM_VOICES)) begin
                cand = cand - CAND_W'(NUM_VOICES);
            end
            if (!pick_valid && bus.voice_req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign start_fetch = bus.s_enable && pick_valid;
    assign timed_out   = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_fetch) state_d = StWait;
            StWait:  if (bus.s_ready || timed_out) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        read_d   = read_q;
        data_d   = data_q;
        ack_d    = '0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_fetch) begin
                    grant_d = pick_idx;
                    addr_d  = bus.voice_addr[pick_idx*ADDR_W +: ADDR_W];
                    read_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                // s_ready takes priority over a coincident timeout.
                if (bus.s_ready) begin
                    data_d         = bus.s_data;
                    read_d         = 1'b0;
                    ack_d[grant_q] = 1'b1;
                end else if (timed_out) begin
                    data_d         = '0;
                    read_d         = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StDone: begin
                rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.voice_ack   = ack_q;
    assign bus.voice_data  = data_q;
    assign bus.s_addr      = addr_q;
    assign bus.s_read      = read_q;
    assign bus.timeout_err = err_q;
    assign bus.busy        = (state_q != StIdle);

endmodule
